block_serializer: RTL and testbench

BLOCK_SERIALIZER -- requirements
Module: block_serializer

---
 rtl/mure_pkg.sv | 8 +
 rtl/block_serializer.sv | 154 +++++++++++++++
 tb/tb_block_serializer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared trace-encoder field widths.
package mure_pkg;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned PRIV_LEN    = 2;
endpackage

// File: rtl/block_serializer.sv
// Compacts up to N retired blocks per cycle into a group FIFO and replays them
// one block per cycle to a ready/valid encoder interface.
module block_serializer
  import mure_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N-1:0]                      valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0]     iretire_i,
  input  logic [N-1:0]                      ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]       itype_i,
  input  logic [N-1:0][XLEN-1:0]            iaddr_i,
  input  logic [CAUSE_LEN-1:0]              cause_i,
  input  logic [XLEN-1:0]                   tval_i,
  input  logic [PRIV_LEN-1:0]               priv_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [IRETIRE_LEN-1:0]            iretire_o,
  output logic                              ilastsize_o,
  output logic [ITYPE_LEN-1:0]              itype_o,
  output logic [XLEN-1:0]                   iaddr_o,
  output logic [CAUSE_LEN-1:0]              cause_o,
  output logic [XLEN-1:0]                   tval_o,
  output logic [PRIV_LEN-1:0]               priv_o,
  output logic                              overflow_o,
  input  logic                              clear_overflow_i,
  output logic [$clog2(FIFO_DEPTH):0]       usage_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned UW = PW + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } blk_t;

  typedef struct packed {
    blk_t [N-1:0]         blk;
    logic [CW-1:0]        cnt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } grp_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state;
  grp_t          mem [FIFO_DEPTH];
  grp_t          wr_grp;
  grp_t          head;
  blk_t          head_blk;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0] usage, usage_nxt;
  logic [CW-1:0] lane_idx;
  logic          overflow_q, drop_pend;
  logic          push_req, full, fire, pop, push, drop;

  // Valid lanes are packed into the low slots in ascending lane order.
  always_comb begin
    wr_grp = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        wr_grp.blk[wr_grp.cnt[LW-1:0]] = '{iretire:   iretire_i[i],
                                           ilastsize: ilastsize_i[i],
                                           itype:     itype_i[i],
                                           iaddr:     iaddr_i[i]};
        wr_grp.cnt = wr_grp.cnt + CW'(1);
      end
    end
    wr_grp.cause = cause_i;
    wr_grp.tval  = tval_i;
    wr_grp.priv  = priv_i;
  end

  assign head     = mem[rd_ptr];
  assign head_blk = head.blk[lane_idx[LW-1:0]];
  assign valid_o  = (state == EMIT);
  assign full     = (usage == UW'(FIFO_DEPTH));
  assign fire     = valid_o && ready_i;
  assign pop      = fire && (lane_idx == head.cnt - CW'(1));
  assign push_req = |valid_i;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    usage_nxt = usage;
    if (push && !pop)      usage_nxt = usage + UW'(1);
    else if (!push && pop) usage_nxt = usage - UW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_grp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usage      <= '0;
      lane_idx   <= '0;
      overflow_q <= 1'b0;
      drop_pend  <= 1'b0;
    end else begin
      usage <= usage_nxt;
      state <= (usage_nxt != '0) ? EMIT : IDLE;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        lane_idx <= '0;
      end else if (fire) begin
        lane_idx <= lane_idx + CW'(1);
      end
      // Clear wins this edge; a masked drop re-raises the flag one edge later.
      if (clear_overflow_i)        overflow_q <= 1'b0;
      else if (drop || drop_pend)  overflow_q <= 1'b1;
      drop_pend <= drop && clear_overflow_i;
    end
  end

  always_comb begin
    iretire_o   = '0;
    ilastsize_o = 1'b0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    if (valid_o) begin
      iretire_o   = head_blk.iretire;
      ilastsize_o = head_blk.ilastsize;
      itype_o     = head_blk.itype;
      iaddr_o     = head_blk.iaddr;
      priv_o      = head.priv;
      if (head_blk.itype == ITYPE_LEN'(1) || head_blk.itype == ITYPE_LEN'(2)) begin
        cause_o = head.cause;
        tval_o  = head.tval;
      end
    end
  end

  assign overflow_o = overflow_q;
  assign usage_o    = usage;

endmodule

// File: tb/tb_block_serializer.sv
// Directed bench for block_serializer with a queue-based reference model.
module tb_block_serializer;
  import mure_pkg::*;

  localparam int N = 2;
  localparam int D = 8;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [N-1:0]                  valid = '0;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire = '0;
  logic [N-1:0]                  ilastsize = '0;
  logic [N-1:0][ITYPE_LEN-1:0]   itype = '0;
  logic [N-1:0][XLEN-1:0]        iaddr = '0;
  logic [CAUSE_LEN-1:0]          cause = '0;
  logic [XLEN-1:0]               tval = '0;
  logic [PRIV_LEN-1:0]           priv = '0;
  logic                          ready = 1'b1;
  logic                          clr = 1'b0;

  logic                          valid_o;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [CAUSE_LEN-1:0]          cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic                          overflow_o;
  logic [$clog2(D):0]            usage_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b1;

  block_serializer #(.N(N), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .iretire_i(iretire),
    .ilastsize_i(ilastsize), .itype_i(itype), .iaddr_i(iaddr),
    .cause_i(cause), .tval_i(tval), .priv_i(priv), .valid_o(valid_o),
    .ready_i(ready), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
    .itype_o(itype_o), .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o), .overflow_o(overflow_o), .clear_overflow_i(clr),
    .usage_o(usage_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of compacted groups plus the index of the next block.
  typedef struct {
    int                     cnt;
    logic [IRETIRE_LEN-1:0] ret  [N];
    logic                   ls   [N];
    logic [ITYPE_LEN-1:0]   ty   [N];
    logic [XLEN-1:0]        addr [N];
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } mgrp_t;

  mgrp_t mq[$];
  int    mlane = 0;
  bit    movf = 0, mpend = 0;

  always @(posedge clk or posedge rst) begin : model
    mgrp_t g;
    bit any, adv, mpop, mfull, dropping;
    if (rst) begin
      mq.delete();
      mlane = 0;
      movf  = 0;
      mpend = 0;
    end else begin
      adv      = (mq.size() > 0) && ready;
      mpop     = adv && (mlane == mq[0].cnt - 1);
      any      = |valid;
      mfull    = (mq.size() == D);
      dropping = any && mfull && !mpop;
      g.cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (valid[i]) begin
          g.ret[g.cnt]  = iretire[i];
          g.ls[g.cnt]   = ilastsize[i];
          g.ty[g.cnt]   = itype[i];
          g.addr[g.cnt] = iaddr[i];
          g.cnt++;
        end
      end
      g.cause = cause;
      g.tval  = tval;
      g.priv  = priv;
      if (clr)                    movf = 0;
      else if (dropping || mpend) movf = 1;
      mpend = dropping && clr;
      if (mpop) begin
        void'(mq.pop_front());
        mlane = 0;
      end else if (adv) begin
        mlane++;
      end
      if (any && !dropping) mq.push_back(g);
    end
  end

  always @(negedge clk) begin : compare
    logic                   ev, els;
    logic [IRETIRE_LEN-1:0] eret;
    logic [ITYPE_LEN-1:0]   ety;
    logic [XLEN-1:0]        ea, et;
    logic [CAUSE_LEN-1:0]   ec;
    logic [PRIV_LEN-1:0]    ep;
    if (cmp_en) begin
      ev = 0; els = 0; eret = '0; ety = '0; ea = '0; et = '0; ec = '0; ep = '0;
      if (mq.size() > 0) begin
        ev   = 1;
        eret = mq[0].ret[mlane];
        els  = mq[0].ls[mlane];
        ety  = mq[0].ty[mlane];
        ea   = mq[0].addr[mlane];
        ep   = mq[0].priv;
        if (ety == 1 || ety == 2) begin
          ec = mq[0].cause;
          et = mq[0].tval;
        end
      end
      chk("m_valid",    64'(valid_o),     64'(ev));
      chk("m_iretire",  64'(iretire_o),   64'(eret));
      chk("m_ilast",    64'(ilastsize_o), 64'(els));
      chk("m_itype",    64'(itype_o),     64'(ety));
      chk("m_iaddr",    64'(iaddr_o),     64'(ea));
      chk("m_cause",    64'(cause_o),     64'(ec));
      chk("m_tval",     64'(tval_o),      64'(et));
      chk("m_priv",     64'(priv_o),      64'(ep));
      chk("m_overflow", 64'(overflow_o),  64'(movf));
      chk("m_usage",    64'(usage_o),     64'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int l, logic [XLEN-1:0] a, logic [ITYPE_LEN-1:0] t,
                          logic [IRETIRE_LEN-1:0] r, logic ls);
    iaddr[l]     = a;
    itype[l]     = t;
    iretire[l]   = r;
    ilastsize[l] = ls;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [XLEN-1:0] exp_addr [8];
    valid = 2'b11;
    set_lane(0, 32'h700, 3'd4, 32'd1, 1'b0);
    set_lane(1, 32'h704, 3'd4, 32'd1, 1'b0);
    @(negedge clk);
    chk("rst_valid",    64'(valid_o),    64'd0);
    chk("rst_usage",    64'(usage_o),    64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_iaddr",    64'(iaddr_o),    64'd0);
    tick();
    rst   = 1'b0;
    valid = '0;
    @(negedge clk);
    chk("post_rst_valid", 64'(valid_o), 64'd0);

    // Two-lane group drains in lane order.
    tick();
    valid = 2'b11; ready = 1'b1; priv = 2'd3;
    set_lane(0, 32'h100, 3'd4, 32'd2, 1'b0);
    set_lane(1, 32'h200, 3'd4, 32'd3, 1'b1);
    tick();
    valid = '0;
    @(negedge clk);
    chk("single_v0", 64'(valid_o), 64'd1);
    chk("single_a0", 64'(iaddr_o), 64'h100);
    chk("single_u0", 64'(usage_o), 64'd1);
    tick();
    @(negedge clk);
    chk("single_a1", 64'(iaddr_o), 64'h200);
    tick();
    @(negedge clk);
    chk("single_end", 64'(valid_o), 64'd0);

    // Gap compaction: only lane 1 valid.
    tick();
    valid = 2'b10;
    set_lane(0, 32'h999, 3'd4, 32'd7, 1'b0);
    set_lane(1, 32'h40,  3'd4, 32'd4, 1'b0);
    tick();
    valid = '0;
    @(negedge clk);
    chk("gap_addr", 64'(iaddr_o), 64'h40);
    tick();
    @(negedge clk);
    chk("gap_end", 64'(valid_o), 64'd0);

    // Backpressure holds the head block.
    tick();
    ready = 1'b0; valid = 2'b11;
    set_lane(0, 32'h300, 3'd4, 32'd6, 1'b0);
    set_lane(1, 32'h304, 3'd4, 32'd8, 1'b1);
    tick();
    valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_addr", 64'(iaddr_o),   64'h300);
      chk("bp_hold_ret",  64'(iretire_o), 64'd6);
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_a0", 64'(iaddr_o), 64'h300);
    tick();
    @(negedge clk);
    chk("bp_rel_a1", 64'(iaddr_o), 64'h304);
    tick();
    @(negedge clk);
    chk("bp_end", 64'(valid_o), 64'd0);

    // Exception fields only for itype 1/2.
    tick();
    valid = 2'b01; cause = 5'd5; tval = 32'hDEAD;
    set_lane(0, 32'h400, 3'd1, 32'd2, 1'b0);
    tick();
    cause = 5'd7; tval = 32'hBEEF;
    set_lane(0, 32'h404, 3'd4, 32'd2, 1'b0);
    @(negedge clk);
    chk("exc_cause", 64'(cause_o), 64'd5);
    chk("exc_tval",  64'(tval_o),  64'hDEAD);
    tick();
    cause = 5'd9; tval = 32'h55;
    set_lane(0, 32'h408, 3'd2, 32'd2, 1'b0);
    @(negedge clk);
    chk("mask_itype", 64'(itype_o), 64'd4);
    chk("mask_cause", 64'(cause_o), 64'd0);
    chk("mask_tval",  64'(tval_o),  64'd0);
    tick();
    valid = '0;
    @(negedge clk);
    chk("exc2_cause", 64'(cause_o), 64'd9);
    chk("exc2_tval",  64'(tval_o),  64'h55);
    cause = '0; tval = '0;
    tick();

    // Overflow: nine groups into eight slots.
    ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      valid = 2'b01;
      set_lane(0, 32'h1000 + 32'(4 * k), 3'd4, 32'd1, 1'b0);
      tick();
    end
    valid = '0;
    @(negedge clk);
    chk("ovf_usage", 64'(usage_o),    64'd8);
    chk("ovf_flag",  64'(overflow_o), 64'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 64'(overflow_o), 64'd0);
    tick();
    ready = 1'b1; valid = 2'b01;
    set_lane(0, 32'h2000, 3'd4, 32'd1, 1'b0);
    tick();
    valid = '0;
    for (int k = 0; k < 7; k++) exp_addr[k] = 32'h1004 + 32'(4 * k);
    exp_addr[7] = 32'h2000;
    @(negedge clk);
    chk("full_pop_usage", 64'(usage_o),    64'd8);
    chk("full_pop_ovf",   64'(overflow_o), 64'd0);
    chk("drain_addr",     64'(iaddr_o),    64'(exp_addr[0]));
    for (int k = 1; k < 8; k++) begin
      tick();
      @(negedge clk);
      chk("drain_addr", 64'(iaddr_o), 64'(exp_addr[k]));
    end
    tick();
    @(negedge clk);
    chk("drain_end",   64'(valid_o), 64'd0);
    chk("drain_usage", 64'(usage_o), 64'd0);

    // Clear coinciding with a drop.
    tick();
    ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid = 2'b01;
      set_lane(0, 32'h3000 + 32'(4 * k), 3'd4, 32'd1, 1'b0);
      tick();
    end
    valid = 2'b01; clr = 1'b1;
    set_lane(0, 32'h3100, 3'd4, 32'd1, 1'b0);
    tick();
    valid = '0; clr = 1'b0;
    @(negedge clk);
    chk("prio_clear", 64'(overflow_o), 64'd0);
    chk("prio_usage", 64'(usage_o),    64'd8);
    tick();
    @(negedge clk);
    chk("prio_reraise", 64'(overflow_o), 64'd1);

    // Reset in the middle of a two-block group.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b1; valid = 2'b11;
    set_lane(0, 32'h500, 3'd4, 32'd1, 1'b0);
    set_lane(1, 32'h504, 3'd4, 32'd1, 1'b0);
    tick();
    valid = '0;
    @(negedge clk);
    chk("midrst_a0", 64'(iaddr_o), 64'h500);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_usage", 64'(usage_o), 64'd0);
    chk("midrst_iaddr", 64'(iaddr_o), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_gone", 64'(valid_o), 64'd0);
      tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
